// File: rtl/ioctrl_pkg.sv
// Shared address map, fill value and FSM encoding for the memory/IO controller.
package ioctrl_pkg;

  localparam logic [31:0] ADDR_LED         = 32'h8000_0000;
  localparam logic [31:0] ADDR_SW          = 32'h8000_0004;
  localparam logic [31:0] ADDR_UART_DATA   = 32'h8000_0008;
  localparam logic [31:0] ADDR_UART_STATUS = 32'h8000_000C;
  localparam logic [31:0] ADDR_CYCLES      = 32'h8000_0010;
  localparam logic [31:0] UNMAPPED_DATA    = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAM_WAIT,
    S_RAM_ACC,
    S_PERIPH,
    S_ACK
  } state_t;

endpackage

// File: rtl/ioctrl_uart_tx.sv
// 8N1 serial transmitter; a start pulse while idle launches one frame of DIV-cycle bits.
module uart_tx #(
  parameter int unsigned DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;

  // shreg holds the bits still to send after the current one, stop bit on top
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      tx      <= 1'b1;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '1;
    end else if (!busy) begin
      if (start) begin
        busy    <= 1'b1;
        tx      <= 1'b0;
        shreg   <= {1'b1, data};
        div_cnt <= '0;
        bit_cnt <= '0;
      end
    end else if (div_cnt == CW'(DIV - 1)) begin
      div_cnt <= '0;
      if (bit_cnt == 4'd9) begin
        busy <= 1'b0;
        tx   <= 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        tx      <= shreg[0];
        shreg   <= {1'b1, shreg[8:1]};
      end
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ioctrl.sv
// Memory/IO controller: decodes arbiter requests to on-chip RAM or peripherals and acks each one.
module ioctrl
  import ioctrl_pkg::*;
#(
  parameter int unsigned RAM_AW   = 12,
  parameter int unsigned RAM_WAIT = 2,
  parameter int unsigned UART_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        mem_ack,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_data_write,
  output logic [31:0] mem_data_read,
  output logic [7:0]  led,
  input  logic [7:0]  sw,
  output logic        uart_tx
);

  localparam int unsigned RAM_WORDS = 2 ** RAM_AW;
  localparam logic [3:0]  WAIT_LAST = 4'(RAM_WAIT - 1);

  // word addresses of the peripheral registers
  localparam logic [29:0] A_LED         = ADDR_LED[31:2];
  localparam logic [29:0] A_SW          = ADDR_SW[31:2];
  localparam logic [29:0] A_UART_DATA   = ADDR_UART_DATA[31:2];
  localparam logic [29:0] A_UART_STATUS = ADDR_UART_STATUS[31:2];
  localparam logic [29:0] A_CYCLES      = ADDR_CYCLES[31:2];

  state_t      state, state_n;
  logic        ack_n;
  logic [31:0] rdata_n;
  logic [7:0]  led_n;
  logic [29:0] addr_q, addr_n;
  logic [31:0] wdata_q, wdata_n;
  logic        we_q, we_n;
  logic [31:0] cyc_q, cyc_n;
  logic [3:0]  wait_q, wait_n;
  logic [31:0] cycle_cnt;
  logic [7:0]  sw_meta, sw_sync;
  logic        uart_busy;
  logic        ram_we_c, uart_start_c, cyc_clr_c;
  logic        unused_addr_lsb_c;

  logic [31:0]       ram [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;

  assign ram_idx           = addr_q[RAM_AW-1:0];
  assign unused_addr_lsb_c = ^mem_addr[1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      mem_ack       <= 1'b0;
      mem_data_read <= '0;
      led           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      cyc_q         <= '0;
      wait_q        <= '0;
    end else begin
      state         <= state_n;
      mem_ack       <= ack_n;
      mem_data_read <= rdata_n;
      led           <= led_n;
      addr_q        <= addr_n;
      wdata_q       <= wdata_n;
      we_q          <= we_n;
      cyc_q         <= cyc_n;
      wait_q        <= wait_n;
    end
  end

  // next-state, request latching and access side effects
  always_comb begin
    state_n      = state;
    ack_n        = 1'b0;
    rdata_n      = mem_data_read;
    led_n        = led;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    we_n         = we_q;
    cyc_n        = cyc_q;
    wait_n       = wait_q;
    ram_we_c     = 1'b0;
    uart_start_c = 1'b0;
    cyc_clr_c    = 1'b0;
    case (state)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          addr_n  = mem_addr[31:2];
          wdata_n = mem_data_write;
          we_n    = mem_write;
          cyc_n   = cycle_cnt;
          wait_n  = '0;
          if (mem_addr[31:28] == 4'h0) begin
            state_n = (RAM_WAIT != 0) ? S_RAM_WAIT : S_RAM_ACC;
          end else begin
            state_n = S_PERIPH;
          end
        end
      end
      S_RAM_WAIT: begin
        wait_n = wait_q + 4'd1;
        if (wait_q == WAIT_LAST) state_n = S_RAM_ACC;
      end
      S_RAM_ACC: begin
        ack_n   = 1'b1;
        state_n = S_ACK;
        if (we_q) ram_we_c = 1'b1;
        else      rdata_n  = ram[ram_idx];
      end
      S_PERIPH: begin
        ack_n   = 1'b1;
        state_n = S_ACK;
        if (we_q) begin
          case (addr_q)
            A_LED:       led_n        = wdata_q[7:0];
            A_UART_DATA: uart_start_c = !uart_busy;
            A_CYCLES:    cyc_clr_c    = 1'b1;
            default:     ;
          endcase
        end else begin
          case (addr_q)
            A_LED:         rdata_n = {24'h0, led};
            A_SW:          rdata_n = {24'h0, sw_sync};
            A_UART_DATA:   rdata_n = '0;
            A_UART_STATUS: rdata_n = {31'h0, uart_busy};
            A_CYCLES:      rdata_n = cyc_q;
            default:       rdata_n = UNMAPPED_DATA;
          endcase
        end
      end
      S_ACK:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we_c) ram[ram_idx] <= wdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cycle_cnt <= '0;
    else if (cyc_clr_c) cycle_cnt <= '0;
    else                cycle_cnt <= cycle_cnt + 32'd1;
  end

  // switches are asynchronous to clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  uart_tx #(.DIV(UART_DIV)) u_uart (
    .clk   (clk),
    .reset (reset),
    .start (uart_start_c),
    .data  (wdata_q[7:0]),
    .busy  (uart_busy),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_ioctrl.sv
// Randomized bench for ioctrl: two instances (RAM_WAIT 2 and 0) against a behavioural model.
module tb_ioctrl;

  localparam logic [31:0] A_LED    = 32'h8000_0000;
  localparam logic [31:0] A_SW     = 32'h8000_0004;
  localparam logic [31:0] A_UDATA  = 32'h8000_0008;
  localparam logic [31:0] A_USTAT  = 32'h8000_000C;
  localparam logic [31:0] A_CYCLES = 32'h8000_0010;
  localparam logic [31:0] BEEF     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sw = 8'h00;
  logic        rd_s [2];
  logic        wr_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] wd_s [2];
  logic        ack_w [2];
  logic [31:0] rdata_w [2];
  logic [7:0]  led_w [2];
  logic        tx_w [2];

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ioctrl #(.RAM_AW(12), .RAM_WAIT(2), .UART_DIV(4)) dut (
    .clk(clk), .reset(reset), .mem_read(rd_s[0]), .mem_write(wr_s[0]), .mem_ack(ack_w[0]),
    .mem_addr(addr_s[0]), .mem_data_write(wd_s[0]), .mem_data_read(rdata_w[0]),
    .led(led_w[0]), .sw(sw), .uart_tx(tx_w[0]));

  ioctrl #(.RAM_AW(12), .RAM_WAIT(0), .UART_DIV(4)) dut_nw (
    .clk(clk), .reset(reset), .mem_read(rd_s[1]), .mem_write(wr_s[1]), .mem_ack(ack_w[1]),
    .mem_addr(addr_s[1]), .mem_data_write(wd_s[1]), .mem_data_read(rdata_w[1]),
    .led(led_w[1]), .sw(sw), .uart_tx(tx_w[1]));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // UART line capture on instance 0
  bit          cap_en = 1'b0;
  int unsigned cap_cyc [$];
  logic        cap_tx [$];
  always @(negedge clk) begin
    if (cap_en) begin
      cap_cyc.push_back(cyc);
      cap_tx.push_back(tx_w[0]);
    end
  end

  int unsigned last_strobe_cyc, last_ack_cyc;

  // Called at a negedge: strobe for one cycle, wait for ack, confirm it is one cycle wide.
  task automatic access(input int d, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdat, output int lat);
    rd_s[d] = rd; wr_s[d] = wr; addr_s[d] = a; wd_s[d] = wd;
    last_strobe_cyc = cyc;
    lat = 0;
    do begin
      @(negedge clk);
      rd_s[d] = 1'b0; wr_s[d] = 1'b0;
      lat++;
    end while (!ack_w[d] && lat < 64);
    if (!ack_w[d]) check("ack_timeout", 32'd0, 32'd1);
    last_ack_cyc = cyc;
    rdat = rdata_w[d];
    @(negedge clk);
    check("ack_single", 32'(ack_w[d]), 32'd0);
  endtask

  // behavioural model
  logic [31:0] mram [int];
  logic [7:0]  mled [2];
  logic [31:0] mlast [2];
  bit          mlast_ok [2];

  task automatic txn(input int d, input logic rd, input logic wr, input logic [31:0] a,
                     input logic [31:0] wd);
    logic [31:0] got, expv, aw;
    int lat, elat, key;
    bit known, is_ram;
    aw     = a & 32'hFFFF_FFFC;
    is_ram = (a[31:28] == 4'h0);
    key    = d * 4096 + int'(a[13:2]);
    elat   = is_ram ? (d == 0 ? 4 : 2) : 2;
    known  = mlast_ok[d];
    expv   = mlast[d];
    if (wr) begin
      if (is_ram) mram[key] = wd;
      else if (aw == A_LED) mled[d] = wd[7:0];
    end else if (rd) begin
      known = 1'b1;
      if (is_ram) begin
        if (mram.exists(key)) expv = mram[key];
        else known = 1'b0;
      end else begin
        case (aw)
          A_LED:    expv = {24'h0, mled[d]};
          A_SW:     expv = {24'h0, sw};
          A_UDATA:  expv = 32'h0;
          A_USTAT:  expv = 32'h0;
          A_CYCLES: known = 1'b0;
          default:  expv = BEEF;
        endcase
      end
    end
    access(d, rd, wr, a, wd, got, lat);
    check(is_ram ? "ram_latency" : "periph_latency", 32'(lat), 32'(elat));
    if (known) check(wr ? "rdata_hold" : "rdata", got, expv);
    check("led", {24'h0, led_w[d]}, {24'h0, mled[d]});
    mlast[d] = expv;
    mlast_ok[d] = known;
  endtask

  logic [31:0] got;
  int          lat;
  int unsigned ack_u, wack;
  logic [9:0]  frame;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 0; wr_s[d] = 0; addr_s[d] = 0; wd_s[d] = 0;
      mled[d] = 0; mlast[d] = 0; mlast_ok[d] = 1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ack", 32'(ack_w[d]), 32'd0);
      check("rst_rdata", rdata_w[d], 32'd0);
      check("rst_led", {24'h0, led_w[d]}, 32'd0);
      check("rst_tx", 32'(tx_w[d]), 32'd1);
    end
    reset = 1'b0;
    @(negedge clk);

    // RAM write/readback on both wait settings
    for (int d = 0; d < 2; d++) begin
      txn(d, 0, 1, 32'h0000_0040, 32'h1234_5678);
      txn(d, 1, 0, 32'h0000_0040, 32'h0);
    end

    // LED, unmapped, switches
    txn(0, 0, 1, A_LED, 32'h0000_01A5);
    txn(0, 1, 0, A_LED, 32'h0);
    txn(0, 1, 0, 32'h9000_0000, 32'h0);
    sw = 8'h3C;
    repeat (3) @(negedge clk);
    txn(0, 1, 0, A_SW, 32'h0);

    // UART frame of 0x55 with a dropped second byte
    cap_en = 1'b1;
    access(0, 0, 1, A_UDATA, 32'h0000_0055, got, lat);
    check("uart_wr_latency", 32'(lat), 32'd2);
    ack_u = last_ack_cyc;
    access(0, 1, 0, A_USTAT, 32'h0, got, lat);
    check("uart_busy", got, 32'd1);
    access(0, 0, 1, A_UDATA, 32'h0000_00FF, got, lat);
    check("uart_drop_latency", 32'(lat), 32'd2);
    repeat (45) @(negedge clk);
    access(0, 1, 0, A_USTAT, 32'h0, got, lat);
    check("uart_idle", got, 32'd0);
    cap_en = 1'b0;
    frame = {1'b1, 8'h55, 1'b0};
    begin
      int n;
      n = 0;
      for (int k = 0; k < cap_cyc.size(); k++) begin
        int i;
        i = int'(cap_cyc[k]) - int'(ack_u);
        if (i >= 0 && i < 44) begin
          n++;
          check("uart_tx", 32'(cap_tx[k]), (i < 40) ? 32'(frame[i / 4]) : 32'd1);
        end
      end
      check("uart_samples", 32'(n), 32'd44);
    end
    mlast[0] = 32'h0;
    mlast_ok[0] = 1'b1;

    // cycle counter: cleared by the write, read back later
    access(1, 0, 1, A_CYCLES, 32'hFFFF_FFFF, got, lat);
    wack = last_ack_cyc;
    repeat (10) @(negedge clk);
    access(1, 1, 0, A_CYCLES, 32'h0, got, lat);
    check("cycles", got, 32'(last_strobe_cyc - wack));
    mlast[1] = 32'(last_strobe_cyc - wack);

    // both strobes: write wins
    txn(0, 1, 1, 32'h0000_0044, 32'hCAFE_F00D);
    txn(0, 1, 0, 32'h0000_0044, 32'h0);

    // reset in the RAM wait window aborts the access
    rd_s[0] = 1'b1; addr_s[0] = 32'h0000_0040;
    @(negedge clk);
    rd_s[0] = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("abort_no_ack", 32'(ack_w[0]), 32'd0);
      @(negedge clk);
    end
    check("abort_rdata", rdata_w[0], 32'd0);
    check("abort_tx", 32'(tx_w[0]), 32'd1);
    for (int d = 0; d < 2; d++) begin
      mled[d] = 0; mlast[d] = 0; mlast_ok[d] = 1;
    end
    sw = 8'h00;
    repeat (3) @(negedge clk);
    txn(0, 1, 0, 32'h0000_0040, 32'h0);

    // random traffic
    for (int t = 0; t < 120; t++) begin
      int d, kind, op;
      logic [31:0] a, wd;
      logic r, w;
      d    = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      op   = int'($urandom_range(0, 2));
      wd   = $urandom;
      r    = (op != 1);
      w    = (op != 0);
      case (kind)
        0, 1: a = {4'h0, 14'($urandom), 12'($urandom_range(16, 23)), 2'($urandom)};
        2:    a = A_LED | 32'($urandom_range(0, 3));
        3: begin
          a = A_SW;
          sw = 8'($urandom);
          repeat (3) @(negedge clk);
        end
        4:    a = A_USTAT;
        default: begin
          a = $urandom;
          if (a[31:28] == 4'h0 || a[31:28] == 4'h8) a[31:28] = 4'h9;
          if (t % 5 == 0) a = 32'h8000_0014;
        end
      endcase
      txn(d, r, w, a, wd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ioctrl.md
Name: ioctrl

Overview:
- Memory/IO controller directly downstream of the memory arbiter; the only consumer of its mem_* request interface.
- Decodes each request address to on-chip RAM or a small memory-mapped peripheral set (LEDs, switches, UART TX, cycle counter), performs the access, then returns a one-cycle mem_ack with read data.
- Requests arrive as single-cycle strobes. Address and write data are held stable by the requester, but the controller latches them anyway.

Parameters:
- RAM_AW, 12, RAM word-address width (2^RAM_AW 32-bit words).
- RAM_WAIT, 2, extra wait cycles on RAM accesses (0..15).
- UART_DIV, 434, clk cycles per UART bit (≥2).

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- mem_read  in  1  one-cycle read strobe
- mem_write  in  1  one-cycle write strobe
- mem_ack  out  1  one-cycle completion pulse
- mem_addr  in  32  byte address, bits [1:0] ignored
- mem_data_write  in  32  write data
- mem_data_read  out  32  read data, valid in the mem_ack cycle, held until the next ack
- led  out  8  LED register
- sw  in  8  asynchronous switch inputs
- uart_tx  out  1  serial TX line, idle high

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: mem_ack=0, mem_data_read=0, led=0, uart_tx=1, cycle counter=0, state=IDLE. RAM contents are undefined (not reset).
- Address map, decoded on latched addr:
  - addr[31:28]==0: RAM word addr[RAM_AW+1:2]; upper bits ignored, so the region aliases.
  - 0x8000_0000 LED: R/W; low 8 bits stored, reads return zero-extended.
  - 0x8000_0004 SW: read only, 2-FF synchronised, zero-extended; writes ignored.
  - 0x8000_0008 UART_DATA: write starts TX of data[7:0] if idle, otherwise the byte is dropped; reads return 0.
  - 0x8000_000C UART_STATUS: read bit0 = tx_busy, others 0; writes ignored.
  - 0x8000_0010 CYCLES: free-running 32-bit counter, wraps 0xFFFF_FFFF→0. Read returns the value at the latch cycle. Any write clears it to 0.
  - Anything else: unmapped. Reads return 0xDEAD_BEEF, writes are discarded, access is still acked.
- FSM states:
  - IDLE: on a strobe, latch addr/data/direction. Go to RAM_WAIT if RAM and RAM_WAIT>0, RAM_ACC if RAM and RAM_WAIT==0, else PERIPH.
  - RAM_WAIT: count RAM_WAIT cycles, then RAM_ACC.
  - RAM_ACC: perform the synchronous RAM read or write, go to ACK.
  - PERIPH: perform the register read or write, go to ACK.
  - ACK: mem_ack=1 for exactly one cycle, mem_data_read updated (reads only; writes leave it unchanged), go to IDLE.
- Latency, with the strobe in cycle T0: peripheral ack in T2; RAM ack in T2+RAM_WAIT.
- mem_read and mem_write both high: write wins, read ignored.
- Strobes arriving outside IDLE are ignored with no ack. The arbiter guarantees none occur.
- Back-to-back: a strobe in the cycle after the ack is accepted.
- UART frame: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), each UART_DIV cycles. tx_busy is high from the cycle after the accepting write until the stop bit completes.
- Reset mid-operation aborts immediately: no ack, UART line returns to 1.

Decomposition:
- Package ioctrl_pkg holds the address constants (ADDR_LED, ADDR_SW, ADDR_UART_DATA, ADDR_UART_STATUS, ADDR_CYCLES), the 0xDEAD_BEEF constant, and the state encoding.
- Sub-module uart_tx (clk, reset, start, data[7:0], busy, tx) with parameter DIV.

Test Plan:
- Reset, then write 0x1234_5678 to 0x0000_0040, then read it back → each acked at T2+RAM_WAIT (T4 at default); readback data 0x1234_5678. Repeat with RAM_WAIT=0 → ack at T2.
- Write 0x0000_01A5 to LED → led=0xA5; LED read returns 0x0000_00A5. Read 0x9000_0000 → 0xDEAD_BEEF, acked at T2.
- sw=0x3C held; read 0x8000_0004 → 0x0000_003C.
- Write 0x55 to UART_DATA with UART_DIV=4 → uart_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles. STATUS reads 1 during TX, 0 after. A second write during TX is dropped but acked.
- Write CYCLES, then read 10 cycles later → small value consistent with the latch timing. Also check both strobes high together → write performed, one ack.
- Assert reset during RAM_WAIT → no ack, state IDLE; the next read is serviced normally.
